ready_gen_mc: RTL and testbench
===============================

Name: ready_gen_mc

Overview:
- Multi-channel, runtime-programmable successor to the fixed-stage ready generator.
- Each channel raises a registered ready a programmable number of clock-enabled edges after its request goes high, and returns the request ID with it.
- Ready drops on the first enabled edge after the request goes low. A changed ID during a request restarts the count.
- Sits between functional units (dividers, memory ports) and the issue/commit logic that waits for multi-cycle results.

Parameters:
- CHAN, 4, number of independent channels.
- WID, 6, request ID width per channel.
- LATW, 4, width of the per-channel latency field; latency range is 0..2**LATW-1.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ce_i  in  1  clock enable, shared by all channels. When low, all state holds.
- i  in  CHAN  per-channel request level.
- lat_i  in  CHAN*LATW  per-channel latency; channel c uses bits [c*LATW +: LATW].
- id_i  in  CHAN*WID  per-channel request ID.
- o  out  CHAN  per-channel ready, registered.
- id_o  out  CHAN*WID  per-channel ID returned with ready. Zero whenever the channel's o is 0.

Behaviour:
- Reset: asynchronous, rst_i high. Forces all channels to IDLE, o=0, id_o=0, counters=0, latched latency/ID=0. Reset mid-count abandons the request with no ready. The first enabled edge after release treats a high i as a new request.
- All transitions below occur only on rising clk_i with ce_i=1. Channels are fully independent.
- Per-channel FSM, states IDLE, COUNT, READY:
  - IDLE, i=0: stay.
  - IDLE, i=1: latch lat and id_i.
    - lat=0: go to READY; o<=1, id_o<=id_i.
    - lat>0: go to COUNT; cnt<=1.
  - COUNT, i=0: go to IDLE; cnt<=0.
  - COUNT, i=1, id_i≠latched ID: restart. Latch the new ID and new lat; cnt<=1, or go to READY if the new lat=0.
  - COUNT, i=1, same ID, cnt==latched lat: go to READY; o<=1, id_o<=latched ID.
  - COUNT, otherwise: cnt<=cnt+1.
  - READY, i=0: go to IDLE; o<=0, id_o<=0.
  - READY, i=1, id_i≠latched ID: o<=0, id_o<=0, restart as from IDLE with the new ID/lat.
  - READY, i=1, same ID: hold o=1.
- Latency: o rises on the (lat+1)th consecutive enabled edge at which i is sampled high with a constant ID. lat=3 gives 4 edges.
- lat_i is sampled only at request start or restart. Changes to lat_i mid-request are ignored.
- cnt is LATW bits wide and never wraps, because it stops at the latched lat ≤ 2**LATW-1.
- Simultaneous i-fall and ID change: i-fall wins (go to IDLE).
- No combinational path from any input to o or id_o.

Optional Feature:
- Macro: READY_GEN_MC_ABORT_CNT_EN.
- When defined:
  - Adds output abort_cnt_o, CHAN*16 bits.
  - Per-channel saturating counter increments on each enabled edge where a COUNT-state request is abandoned by i=0 or by an ID-change restart.
  - Saturates at 16'hFFFF.
  - Cleared by rst_i.
- When undefined: the port and the counters are absent. All other behaviour is identical.

Decomposition:
- Package ready_gen_mc_pkg holds:
  - state encoding typedef (IDLE=2'd0, COUNT=2'd1, READY=2'd2);
  - abort counter width constant ABORT_W=16.
- Sub-module ready_gen_ch (one channel: FSM, counter, latched lat/ID, optional abort counter). Instantiated CHAN times in a generate loop. The top only slices vectors and ties ce_i/rst_i.

Test Plan:
- Channel 0, lat=3, id=6'h15, i held high → o[0] rises on the 4th enabled edge, id_o=6'h15. i low → o[0]=0 and id_o=0 on the next enabled edge.
- lat=0, i pulses high for one cycle → o high for exactly one cycle, one edge later, with the matching ID.
- lat=5, toggle ce_i low for 3 cycles mid-count → o rise is delayed by exactly 3 cycles. State holds while ce_i=0.
- lat=4, ID changes 6'h01→6'h02 after 2 edges → count restarts. o rises 5 edges after the change with id_o=6'h02. With the macro defined, abort_cnt_o[0]=1.
- Assert rst_i asynchronously mid-clock while channel 2 is READY → o[2], id_o immediately 0 without a clock edge. After release with i still high, o returns after lat+1 edges.
- All 4 channels with lat 0,1,7,15 and staggered i → each rises independently at its own latency. No cross-channel interference.

Source files
------------

// File: rtl/ready_gen_mc_pkg.sv
// Shared types and constants for the multi-channel ready generator.
package ready_gen_mc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        READY = 2'd2
    } ch_state_e;

    localparam int ABORT_W = 16;

endpackage

// File: rtl/ready_gen_mc_if.sv
// Request/ready bundle between issue logic (master) and ready_gen_mc (slave).
// abort_cnt_o exists only with READY_GEN_MC_ABORT_CNT_EN.
interface ready_gen_mc_if
    import ready_gen_mc_pkg::*;
#(
    parameter int CHAN = 4,
    parameter int WID  = 6,
    parameter int LATW = 4
);
    logic [CHAN-1:0]      i;
    logic [CHAN*LATW-1:0] lat_i;
    logic [CHAN*WID-1:0]  id_i;
    logic [CHAN-1:0]      o;
    logic [CHAN*WID-1:0]  id_o;
`ifdef READY_GEN_MC_ABORT_CNT_EN
    logic [CHAN*ABORT_W-1:0] abort_cnt_o;

    modport master (output i, lat_i, id_i, input o, id_o, abort_cnt_o);
    modport slave  (input i, lat_i, id_i, output o, id_o, abort_cnt_o);
`else
    modport master (output i, lat_i, id_i, input o, id_o);
    modport slave  (input i, lat_i, id_i, output o, id_o);
`endif
endinterface

// File: rtl/ready_gen_mc_ch.sv
// One ready-generator channel: FSM, latency counter, latched lat/ID.
// Optional abort counter under READY_GEN_MC_ABORT_CNT_EN.
module ready_gen_ch
    import ready_gen_mc_pkg::*;
#(
    parameter int WID  = 6,
    parameter int LATW = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            i_ce,
    input  logic            i_req,
    input  logic [LATW-1:0] i_lat,
    input  logic [WID-1:0]  i_id,
`ifdef READY_GEN_MC_ABORT_CNT_EN
    output logic [ABORT_W-1:0] o_abort_cnt,
`endif
    output logic            o_rdy,
    output logic [WID-1:0]  o_id
);
    ch_state_e       r_st,   w_st;
    logic [LATW-1:0] r_cnt,  w_cnt;
    logic [LATW-1:0] r_lat,  w_lat;
    logic [WID-1:0]  r_id,   w_id;
    logic            r_rdy,  w_rdy;
    logic [WID-1:0]  r_ido,  w_ido;
    logic            w_start;
    logic            w_abort;
    logic            w_chg;

    assign w_chg = (i_id != r_id);

    always_comb begin
        w_st    = r_st;
        w_cnt   = r_cnt;
        w_lat   = r_lat;
        w_id    = r_id;
        w_rdy   = r_rdy;
        w_ido   = r_ido;
        w_start = 1'b0;
        w_abort = 1'b0;
        unique case (r_st)
            IDLE: begin
                w_start = i_req;
            end
            COUNT: begin
                if (!i_req) begin
                    w_st    = IDLE;
                    w_cnt   = '0;
                    w_abort = 1'b1;
                end else if (w_chg) begin
                    w_start = 1'b1;
                    w_abort = 1'b1;
                end else if (r_cnt == r_lat) begin
                    w_st  = READY;
                    w_rdy = 1'b1;
                    w_ido = r_id;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            READY: begin
                if (!i_req) begin
                    w_st  = IDLE;
                    w_cnt = '0;
                    w_rdy = 1'b0;
                    w_ido = '0;
                end else if (w_chg) begin
                    w_start = 1'b1;
                end
            end
            default: begin
                w_st = IDLE;
            end
        endcase
        // A (re)start counts this edge as the first of the new request
        if (w_start) begin
            w_lat = i_lat;
            w_id  = i_id;
            if (i_lat == '0) begin
                w_st  = READY;
                w_cnt = '0;
                w_rdy = 1'b1;
                w_ido = i_id;
            end else begin
                w_st  = COUNT;
                w_cnt = {{(LATW-1){1'b0}}, 1'b1};
                w_rdy = 1'b0;
                w_ido = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_st  <= IDLE;
            r_cnt <= '0;
            r_lat <= '0;
            r_id  <= '0;
            r_rdy <= 1'b0;
            r_ido <= '0;
        end else if (i_ce) begin
            r_st  <= w_st;
            r_cnt <= w_cnt;
            r_lat <= w_lat;
            r_id  <= w_id;
            r_rdy <= w_rdy;
            r_ido <= w_ido;
        end
    end

`ifdef READY_GEN_MC_ABORT_CNT_EN
    logic [ABORT_W-1:0] r_abort;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_abort <= '0;
        end else if (i_ce && w_abort && (r_abort != '1)) begin
            r_abort <= r_abort + 1'b1;
        end
    end

    assign o_abort_cnt = r_abort;
`endif

    assign o_rdy = r_rdy;
    assign o_id  = r_ido;
endmodule

// File: rtl/ready_gen_mc.sv
// Multi-channel programmable-latency ready generator; one ready_gen_ch per channel.
// Define READY_GEN_MC_ABORT_CNT_EN to add per-channel abort counters.
module ready_gen_mc
    import ready_gen_mc_pkg::*;
#(
    parameter int CHAN = 4,
    parameter int WID  = 6,
    parameter int LATW = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ce_i,
    ready_gen_mc_if.slave bus
);
    logic [CHAN-1:0]     w_o;
    logic [CHAN*WID-1:0] w_id_o;
`ifdef READY_GEN_MC_ABORT_CNT_EN
    logic [CHAN*ABORT_W-1:0] w_abort;
    assign bus.abort_cnt_o = w_abort;
`endif

    for (genvar g = 0; g < CHAN; g++) begin : g_ch
        ready_gen_ch #(
            .WID  (WID),
            .LATW (LATW)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .i_ce        (ce_i),
            .i_req       (bus.i[g]),
            .i_lat       (bus.lat_i[g*LATW +: LATW]),
            .i_id        (bus.id_i[g*WID +: WID]),
`ifdef READY_GEN_MC_ABORT_CNT_EN
            .o_abort_cnt (w_abort[g*ABORT_W +: ABORT_W]),
`endif
            .o_rdy       (w_o[g]),
            .o_id        (w_id_o[g*WID +: WID])
        );
    end

    assign bus.o    = w_o;
    assign bus.id_o = w_id_o;
endmodule

// File: tb/tb_ready_gen_mc.sv
// Directed and randomized bench for ready_gen_mc against a request-run model.
`timescale 1ns/1ps
module tb_ready_gen_mc;
    localparam int CHAN = 4;
    localparam int WID  = 6;
    localparam int LATW = 4;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    logic [CHAN-1:0] req;
    logic [LATW-1:0] lat [CHAN];
    logic [WID-1:0]  id  [CHAN];

    ready_gen_mc_if #(.CHAN(CHAN), .WID(WID), .LATW(LATW)) bus ();

    ready_gen_mc #(.CHAN(CHAN), .WID(WID), .LATW(LATW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ce_i  (ce),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.i = req;
    for (genvar g = 0; g < CHAN; g++) begin : g_drv
        assign bus.lat_i[g*LATW +: LATW] = lat[g];
        assign bus.id_i[g*WID +: WID]    = id[g];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Model: length of the current run of enabled edges with i high and a
    // constant ID; ready once that run reaches lat+1.
    int             run  [CHAN];
    int             mlat [CHAN];
    logic [WID-1:0] mid  [CHAN];
    logic           m_o  [CHAN];
    logic [WID-1:0] m_ido[CHAN];
    int             mab  [CHAN];

    task automatic model_reset();
        for (int c = 0; c < CHAN; c++) begin
            run[c] = 0; mlat[c] = 0; mid[c] = '0;
            m_o[c] = 1'b0; m_ido[c] = '0; mab[c] = 0;
        end
    endtask

    task automatic model_step();
        bit counting;
        for (int c = 0; c < CHAN; c++) begin
            counting = (run[c] > 0) && (run[c] < mlat[c] + 1);
            if (!req[c]) begin
                if (counting && mab[c] < 65535) mab[c]++;
                run[c] = 0;
            end else if (run[c] == 0 || id[c] != mid[c]) begin
                if (counting && mab[c] < 65535) mab[c]++;
                mid[c]  = id[c];
                mlat[c] = int'(lat[c]);
                run[c]  = 1;
            end else if (run[c] < 100) begin
                run[c]++;
            end
            m_o[c]   = req[c] && (run[c] >= mlat[c] + 1);
            m_ido[c] = m_o[c] ? mid[c] : '0;
        end
    endtask

    task automatic compare();
        for (int c = 0; c < CHAN; c++) begin
            chk($sformatf("o%0d", c), 64'(bus.o[c]), 64'(m_o[c]));
            chk($sformatf("id_o%0d", c), 64'(bus.id_o[c*WID +: WID]),
                64'(m_ido[c]));
`ifdef READY_GEN_MC_ABORT_CNT_EN
            chk($sformatf("abort%0d", c),
                64'(bus.abort_cnt_o[c*16 +: 16]), 64'(mab[c]));
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst && ce) model_step();
        #1;
        compare();
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        req = '0;
        for (int c = 0; c < CHAN; c++) begin
            lat[c] = '0; id[c] = '0;
        end
        model_reset();
        #2;
        chk("rst_o", 64'(bus.o), 64'd0);
        chk("rst_id", 64'(bus.id_o), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        ce = 1'b1;

        // lat=3 held: ready on the 4th edge
        lat[0] = 4'd3; id[0] = 6'h15; req[0] = 1'b1;
        repeat (3) tick();
        chk("lat3_early", 64'(bus.o[0]), 64'd0);
        tick();
        chk("lat3_rise", 64'(bus.o[0]), 64'd1);
        chk("lat3_id", 64'(bus.id_o[5:0]), 64'h15);
        req[0] = 1'b0;
        tick();
        chk("lat3_fall", 64'(bus.o[0]), 64'd0);
        chk("lat3_idz", 64'(bus.id_o[5:0]), 64'd0);

        // lat=0 single-cycle pulse
        lat[0] = 4'd0; id[0] = 6'h2A; req[0] = 1'b1;
        tick();
        chk("lat0_rise", 64'(bus.o[0]), 64'd1);
        chk("lat0_id", 64'(bus.id_o[5:0]), 64'h2A);
        req[0] = 1'b0;
        tick();
        chk("lat0_fall", 64'(bus.o[0]), 64'd0);

        // lat=5 with ce low for 3 cycles mid-count
        lat[0] = 4'd5; id[0] = 6'h03; req[0] = 1'b1;
        repeat (2) tick();
        ce = 1'b0;
        lat[0] = 4'd0;
        repeat (3) tick();
        chk("ce_hold", 64'(bus.o[0]), 64'd0);
        ce = 1'b1;
        repeat (3) tick();
        chk("ce_early", 64'(bus.o[0]), 64'd0);
        tick();
        chk("ce_rise", 64'(bus.o[0]), 64'd1);
        req[0] = 1'b0;
        tick();

        // ID change mid-count restarts
        lat[0] = 4'd4; id[0] = 6'h01; req[0] = 1'b1;
        repeat (2) tick();
        id[0] = 6'h02;
        repeat (4) tick();
        chk("idchg_early", 64'(bus.o[0]), 64'd0);
        tick();
        chk("idchg_rise", 64'(bus.o[0]), 64'd1);
        chk("idchg_id", 64'(bus.id_o[5:0]), 64'h02);
`ifdef READY_GEN_MC_ABORT_CNT_EN
        chk("idchg_abort", 64'(bus.abort_cnt_o[15:0]), 64'd1);
`endif
        req[0] = 1'b0;
        tick();

        // async reset while channel 2 is READY
        lat[2] = 4'd2; id[2] = 6'h09; req[2] = 1'b1;
        repeat (3) tick();
        chk("ar_ready", 64'(bus.o[2]), 64'd1);
        @(posedge clk);
        model_step();
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("ar_o", 64'(bus.o), 64'd0);
        chk("ar_id", 64'(bus.id_o), 64'd0);
        #2 rst = 1'b0;
        repeat (2) tick();
        chk("ar_early", 64'(bus.o[2]), 64'd0);
        tick();
        chk("ar_rise", 64'(bus.o[2]), 64'd1);
        chk("ar_rid", 64'(bus.id_o[17:12]), 64'h09);
        req = '0;
        tick();

        // all channels, staggered starts, distinct latencies
        lat[0] = 4'd0; lat[1] = 4'd1; lat[2] = 4'd7; lat[3] = 4'd15;
        for (int c = 0; c < CHAN; c++) id[c] = WID'(c + 8'h30);
        for (int c = 0; c < CHAN; c++) begin
            req[c] = 1'b1;
            tick();
        end
        repeat (16) tick();
        chk("multi_all", 64'(bus.o), 64'hF);
        req = '0;
        tick();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            ce = ($urandom_range(0, 7) != 0);
            for (int c = 0; c < CHAN; c++) begin
                if ($urandom_range(0, 5) == 0) req[c] = ~req[c];
                if ($urandom_range(0, 9) == 0) id[c] = WID'($urandom_range(0, 3));
                lat[c] = ($urandom_range(0, 7) == 0) ? 4'd15
                                                     : LATW'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 499) == 0) begin
                #3 rst = 1'b1;
                #1 model_reset();
                chk("rnd_rst", 64'(bus.o), 64'd0);
                #1 rst = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
